avalon_st_mult_source: RTL and testbench

//  Initiator end of the Avalon-ST multiplier link. Buffers operand pairs from a local command port.

---
 rtl/avalon_st_mult_source.sv | 183 ++++++++++++++++++
 tb/tb_avalon_st_mult_source.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_st_mult_source.sv
// ---------------------------------------------------------------------------
// avalon_st_mult_source
//   Initiator end of the Avalon-ST multiplier link. Operand pairs arrive on
//   a local command port and are queued in a small FIFO. They are streamed as
//   {a,b} beats to the multiplier slave. The 2*SZ-bit products come back on a
//   sink channel and are forwarded, in issue order, through a one-entry
//   response register. The number of beats sent but not yet answered is
//   capped at MAX_OUT.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             1-cycle pulse: drop queued commands, drain in-flight work
//   cmd_valid/ready   command handshake, operands cmd_a / cmd_b (SZ bits each)
//   src_valid/ready   Avalon-ST source (readyLatency 0), src_data = {a,b}
//   snk_valid/ready   Avalon-ST sink carrying products, snk_data (2*SZ bits)
//   rsp_valid/ready   result handshake, rsp_data (2*SZ bits)
//   outstanding       beats in flight
//   fifo_level        queued commands
//   busy              FSM not idle
//   err_unexp         sticky: product arrived with nothing outstanding
// ---------------------------------------------------------------------------
module avalon_st_mult_source #(
    parameter int SZ      = 32,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [SZ-1:0]                  cmd_a,
    input  logic [SZ-1:0]                  cmd_b,
    output logic                           src_valid,
    input  logic                           src_ready,
    output logic [2*SZ-1:0]                src_data,
    input  logic                           snk_valid,
    output logic                           snk_ready,
    input  logic [2*SZ-1:0]                snk_data,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [2*SZ-1:0]                rsp_data,
    output logic [$clog2(MAX_OUT+1)-1:0]   outstanding,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_level,
    output logic                           busy,
    output logic                           err_unexp
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
    localparam logic [OW-1:0] MAX_OUT_L = OW'(MAX_OUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state_reg, state_next;

    // Command storage; the head entry is read combinationally so a beat can
    // be offered the cycle after its command was accepted.
    logic [2*SZ-1:0]   mem [DEPTH];
    logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]     level_reg;
    logic [OW-1:0]     out_reg, out_next;
    logic [2*SZ-1:0]   rsp_data_reg;
    logic              rsp_valid_reg;
    logic              err_reg;

    logic              fifo_empty;
    logic              push, pop;
    logic              snk_fire, snk_take, snk_unexp;

    // ---------------------------------------------------------------------
    // Handshake decode
    // ---------------------------------------------------------------------
    assign fifo_empty = (level_reg == '0);
    assign cmd_ready  = (level_reg < DEPTH_L) && (state_reg != ST_FLUSH);
    assign src_valid  = !fifo_empty && (out_reg < MAX_OUT_L) && (state_reg != ST_FLUSH);
    assign src_data   = mem[rd_ptr_reg];
    assign snk_ready  = !rsp_valid_reg || rsp_ready;

    assign push      = cmd_valid && cmd_ready;
    assign pop       = src_valid && src_ready;
    assign snk_fire  = snk_valid && snk_ready;
    // A product with nothing outstanding is accepted off the bus but dropped.
    assign snk_unexp = snk_fire && (out_reg == '0);
    assign snk_take  = snk_fire && (out_reg != '0);

    always_comb begin
        out_next = out_reg;
        case ({pop, snk_take})
            2'b10:   out_next = out_reg + OW'(1);
            2'b01:   out_next = out_reg - OW'(1);
            default: out_next = out_reg;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            // Nothing left to drain after this edge: skip FLUSH entirely.
            state_next = (out_next == '0) ? ST_IDLE : ST_FLUSH;
        end else begin
            case (state_reg)
                ST_IDLE:  if (level_reg != '0) state_next = ST_RUN;
                ST_RUN:   if (fifo_empty && (out_reg == '0)) state_next = ST_IDLE;
                ST_FLUSH: if (out_reg == '0) state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // Command FIFO
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // In-flight counter, response register, error flag
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            err_reg       <= 1'b0;
        end else begin
            out_reg <= out_next;
            if (snk_take) begin
                rsp_valid_reg <= 1'b1;
                rsp_data_reg  <= snk_data;
            end else if (rsp_ready) begin
                rsp_valid_reg <= 1'b0;
            end
            if (snk_unexp) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign rsp_valid   = rsp_valid_reg;
    assign rsp_data    = rsp_data_reg;
    assign outstanding = out_reg;
    assign fifo_level  = level_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign err_unexp   = err_reg;

endmodule

// File: tb/tb_avalon_st_mult_source.sv
// ---------------------------------------------------------------------------
// tb_avalon_st_mult_source
//   Directed bench for avalon_st_mult_source (SZ=32, DEPTH=4, MAX_OUT=2).
//   Inputs change just after the falling edge; outputs are checked at the
//   falling edge, i.e. half a cycle after the rising edge that updated them.
// ---------------------------------------------------------------------------
module tb_avalon_st_mult_source;

    localparam int SZ = 32;

    logic          clk = 1'b0;
    logic          rst, flush;
    logic          cmd_valid, cmd_ready;
    logic [SZ-1:0] cmd_a, cmd_b;
    logic          src_valid, src_ready;
    logic [63:0]   src_data;
    logic          snk_valid, snk_ready;
    logic [63:0]   snk_data;
    logic          rsp_valid, rsp_ready;
    logic [63:0]   rsp_data;
    logic [1:0]    outstanding;
    logic [2:0]    fifo_level;
    logic          busy, err_unexp;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    avalon_st_mult_source #(.SZ(SZ), .DEPTH(4), .MAX_OUT(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .outstanding(outstanding), .fifo_level(fifo_level),
        .busy(busy), .err_unexp(err_unexp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Bounded wait for the in-flight count to reach n.
    task automatic wait_out(input int n);
        int k = 0;
        while (outstanding !== 2'(n) && k < 20) begin
            cyc();
            k++;
        end
        chk("wait_outstanding", 64'(outstanding), 64'(n));
    endtask

    initial begin
        logic [63:0] px, py;
        rst = 1'b1; flush = 0; cmd_valid = 0; cmd_a = 0; cmd_b = 0;
        src_ready = 0; snk_valid = 0; snk_data = 0; rsp_ready = 0;
        do_reset();
        cyc();

        // ---- reset values
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_snk_ready", 64'(snk_ready), 64'd1);
        chk("rst_src_valid", 64'(src_valid), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_fifo_level", 64'(fifo_level), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_unexp), 64'd0);
        $display("txn reset checked");

        // ---- 1. single op 3*5
        cmd_valid = 1; cmd_a = 3; cmd_b = 5; src_ready = 1;
        cyc();
        cmd_valid = 0;
        chk("t1_src_valid", 64'(src_valid), 64'd1);
        chk("t1_src_data", src_data, 64'h00000003_00000005);
        cyc();
        chk("t1_out_1", 64'(outstanding), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_src_valid_off", 64'(src_valid), 64'd0);
        cyc();
        snk_valid = 1; snk_data = 64'd15;
        cyc();
        snk_valid = 0; rsp_ready = 1;
        chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t1_rsp_data", rsp_data, 64'd15);
        chk("t1_out_0", 64'(outstanding), 64'd0);
        cyc();
        chk("t1_rsp_done", 64'(rsp_valid), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);
        $display("txn single op 3*5 -> %0d", 15);

        // ---- 2. fill FIFO with src_ready=0
        src_ready = 0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1; cmd_a = 32'(10 + i); cmd_b = 32'(20 + i);
            cyc();
            chk("t2_cmd_ready", 64'(cmd_ready), (i < 3) ? 64'd1 : 64'd0);
            $display("txn fill offer %0d cmd_ready=%0b", i, cmd_ready);
        end
        cmd_valid = 0;
        chk("t2_level", 64'(fifo_level), 64'd4);
        chk("t2_src_data", src_data, {32'd10, 32'd20});
        cyc();
        chk("t2_src_hold", src_data, {32'd10, 32'd20});
        chk("t2_src_valid_hold", 64'(src_valid), 64'd1);

        // ---- 3. window limit, slave silent
        src_ready = 1;
        cyc();
        chk("t3_out_1", 64'(outstanding), 64'd1);
        chk("t3_next_head", src_data, {32'd11, 32'd21});
        cyc();
        chk("t3_out_2", 64'(outstanding), 64'd2);
        chk("t3_src_blocked", 64'(src_valid), 64'd0);
        chk("t3_level", 64'(fifo_level), 64'd2);
        cyc();
        chk("t3_still_blocked", 64'(src_valid), 64'd0);
        chk("t3_out_still_2", 64'(outstanding), 64'd2);
        snk_valid = 1; snk_data = 64'd200; rsp_ready = 1;
        cyc();
        snk_valid = 0;
        chk("t3_released_out", 64'(outstanding), 64'd1);
        chk("t3_released_valid", 64'(src_valid), 64'd1);
        chk("t3_released_data", src_data, {32'd12, 32'd22});
        chk("t3_rsp_data", rsp_data, 64'd200);
        cyc();
        chk("t3_out_back_2", 64'(outstanding), 64'd2);
        $display("txn window limit checked");

        // ---- rst mid-operation
        src_ready = 0; rsp_ready = 0;
        do_reset();
        chk("rst_mid_out", 64'(outstanding), 64'd0);
        chk("rst_mid_level", 64'(fifo_level), 64'd0);
        chk("rst_mid_rsp", 64'(rsp_valid), 64'd0);

        // ---- 4. backpressure and order over 8 ops (4 pairs)
        for (int p = 0; p < 4; p++) begin
            px = 64'((2 * p + 1) * 9);
            py = 64'((2 * p + 2) * 9);
            rsp_ready = 0;
            cmd_valid = 1; cmd_a = 32'(2 * p + 1); cmd_b = 32'd9;
            cyc();
            cmd_a = 32'(2 * p + 2);
            cyc();
            cmd_valid = 0; src_ready = 1;
            wait_out(2);
            src_ready = 0;
            snk_valid = 1; snk_data = px;
            cyc();
            snk_data = py;
            chk("t4_first", rsp_data, px);
            chk("t4_snk_ready_low", 64'(snk_ready), 64'd0);
            cyc();
            chk("t4_first_held", rsp_data, px);
            rsp_ready = 1;
            cyc();
            snk_valid = 0;
            chk("t4_second", rsp_data, py);
            chk("t4_second_valid", 64'(rsp_valid), 64'd1);
            cyc();
            chk("t4_drained", 64'(rsp_valid), 64'd0);
            chk("t4_out_0", 64'(outstanding), 64'd0);
            $display("txn pair %0d products %0d,%0d", p, px, py);
        end
        rsp_ready = 0;
        cyc();

        // ---- 5. flush with 3 queued and 1 in flight
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1; cmd_a = 32'(40 + i); cmd_b = 32'd1;
            cyc();
        end
        cmd_valid = 0; src_ready = 1;
        cyc();
        src_ready = 0;
        chk("t5_out_1", 64'(outstanding), 64'd1);
        chk("t5_level_3", 64'(fifo_level), 64'd3);
        flush = 1;
        cyc();
        flush = 0;
        chk("t5_level_0", 64'(fifo_level), 64'd0);
        chk("t5_busy", 64'(busy), 64'd1);
        chk("t5_src_withdrawn", 64'(src_valid), 64'd0);
        chk("t5_cmd_blocked", 64'(cmd_ready), 64'd0);
        cyc();
        chk("t5_busy_hold", 64'(busy), 64'd1);
        snk_valid = 1; snk_data = 64'd40; rsp_ready = 1;
        cyc();
        snk_valid = 0;
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t5_rsp_data", rsp_data, 64'd40);
        cyc();
        chk("t5_idle", 64'(busy), 64'd0);
        chk("t5_cmd_ready", 64'(cmd_ready), 64'd1);
        $display("txn flush drained product %0d", 40);

        // flush while idle with nothing in flight stays idle
        flush = 1;
        cyc();
        flush = 0;
        chk("t5_idle_flush", 64'(busy), 64'd0);

        // ---- 6. spurious product
        rsp_ready = 0;
        snk_valid = 1; snk_data = 64'd99;
        cyc();
        snk_valid = 0;
        chk("t6_err", 64'(err_unexp), 64'd1);
        chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t6_out", 64'(outstanding), 64'd0);
        cyc();
        chk("t6_err_sticky", 64'(err_unexp), 64'd1);
        do_reset();
        chk("t6_err_cleared", 64'(err_unexp), 64'd0);
        $display("txn spurious beat checked");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
